hififo_rr_scheduler: RTL and testbench
======================================

HIFIFO_RR_SCHEDULER -- requirements
Module: hififo_rr_scheduler

Interface
REQ-001 SHALL have parameter PIO_ADDR, default 11'd9, the PIO register address for enable/flush control.
REQ-002 SHALL have parameter SLOTS, default 8, the outstanding read-request tags per requester (power of 2, max 8).
REQ-003 SHALL have port clock, input, 1, the single PCIe user clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pio_wvalid, input, 1, PIO write strobe.
REQ-006 SHALL have port pio_addr, input, 11, PIO write address.
REQ-007 SHALL have port pio_wdata, input, 64, PIO write data.
REQ-008 SHALL have port rr_valid, input, 4, per-requester read-request valid.
REQ-009 SHALL have port rr_ready, output, 4, per-requester one-cycle accept pulse.
REQ-010 SHALL have ports rr0_addr..rr3_addr, input, 64 each, requester read addresses.
REQ-011 SHALL have port rrm_valid, output, 1, multiplexed request valid to the TX engine.
REQ-012 SHALL have port rrm_addr, output, 64, multiplexed request address.
REQ-013 SHALL have port rrm_tag, output, 8, PCIe tag: {3'b000, requester[1:0], slot[2:0]}.
REQ-014 SHALL have port rrm_ready, input, 1, TX engine accept.
REQ-015 SHALL have ports rc_valid, input, 1, and rc_tag, input, 8, carrying completion tag from RX.
REQ-016 SHALL have port rc_last, input, 1, marking the final completion beat for rc_tag.
REQ-017 SHALL have port busy, output, 32, outstanding-tag bitmap (bit index = rrm_tag[4:0]).
REQ-018 SHALL have port error, output, 1, sticky flag for an unexpected completion.

Function
REQ-019 SHALL implement two states, IDLE and ISSUE.
REQ-020 In IDLE, requester i SHALL be eligible when rr_valid[i], enable[i], and a free slot exists for i.
REQ-021 In IDLE, arbitration SHALL be round-robin, starting from pointer p; the pointer SHALL move to grantee+1 mod 4 after a grant.
REQ-022 On grant: rr_ready[grantee] SHALL pulse for exactly that cycle; rrm_addr <= rrN_addr; rrm_tag <= lowest free slot; that busy bit set; go to ISSUE.
REQ-023 In ISSUE, rrm_valid SHALL be 1, with rrm_addr and rrm_tag held stable; on rrm_ready, go to IDLE with rrm_valid deasserted the next cycle.
REQ-024 Grant-to-grant throughput SHALL be at most one request per 2 cycles; latency from eligible to rrm_valid SHALL be 1 cycle.
REQ-025 rc_valid && rc_last with rc_tag[7:5]==0 and a set busy bit SHALL clear that bit on the next edge.
REQ-026 A completion whose tag bit is clear, or whose rc_tag[7:5]!=0, or whose slot >= SLOTS, SHALL set error and otherwise be ignored.
REQ-027 rc_valid without rc_last SHALL not change busy.
REQ-028 A same-cycle allocation and release SHALL both take effect.
REQ-029 A PIO write at PIO_ADDR SHALL set enable <= pio_wdata[3:0] and clear busy bits of every requester i with pio_wdata[8+i]=1.
REQ-030 A flush SHALL take priority over a same-cycle allocation to the same requester.
REQ-031 Disabling or flushing a requester while in ISSUE SHALL NOT withdraw the pending rrm request.
REQ-032 A requester with all SLOTS busy SHALL be skipped without stalling the others.

Reset
REQ-033 On reset: state IDLE; rrm_valid=0; rr_ready=0; busy=0; error=0; enable=4'b0001; p=0; rrm_addr=0; rrm_tag=0.
REQ-034 Reset asserted mid-ISSUE SHALL drop the request; rrm_valid SHALL be 0 the cycle after reset is sampled.

Structure
REQ-035 Tag field widths, state encoding and the PIO_ADDR default SHALL live in the shared hififo package.
REQ-036 Round-robin selection SHALL be one sub-module, hififo_rr_arb4 (4-bit request in, one-hot grant out, pointer in).

Verification
REQ-037 After reset, rr_valid=4'b0001, rr0_addr=64'h1000, rrm_ready held at 1 -> rr_ready[0] pulses once, rrm_tag=8'h00, busy=32'h1; the next grant gets tag 8'h01.
REQ-038 After enable=4'hF, all rr_valid high, rrm_ready=1 -> grant order 0,1,2,3,0 with tags 00,08,10,18,01.
REQ-039 Requester 0 fills 8 slots with no completions -> ninth rr_valid[0] not granted, requester 1 still served; rc_valid+rc_last tag 8'h03 -> next requester-0 tag 8'h03.
REQ-040 rrm_ready held at 0 for 5 cycles -> rrm_valid, rrm_addr and rrm_tag stable, no further rr_ready pulses.
REQ-041 Completion with tag 8'h05 while busy[5]=0 -> error=1 and busy unchanged; PIO write at PIO_ADDR with data 64'h1_0F -> busy[7:0]=0, enable=4'hF.
REQ-042 Reset asserted during ISSUE -> next cycle rrm_valid=0, busy=0, enable=4'b0001.

Source files
------------

// File: rtl/hififo_pkg.sv
// rtl/hififo_pkg.sv - shared tag layout, FSM encoding and PIO defaults for the hififo read scheduler
package hififo_pkg;

  localparam logic [10:0] HIFIFO_PIO_ADDR = 11'd9;
  localparam int REQ_W  = 2;
  localparam int SLOT_W = 3;
  localparam int TAG_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Returns {found, slot}; scanning downward leaves the lowest usable free slot.
  function automatic logic [SLOT_W:0] lowest_free(input logic [7:0] used, input int slots);
    logic [SLOT_W:0] res;
    res = '0;
    for (int s = 7; s >= 0; s--) begin
      if (s < slots && !used[s]) res = {1'b1, SLOT_W'(s)};
    end
    return res;
  endfunction

endpackage

// File: rtl/hififo_rr_arb4.sv
// rtl/hififo_rr_arb4.sv - four-way round-robin selector, first request at or after ptr wins
module hififo_rr_arb4
  import hififo_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [REQ_W-1:0] ptr,
  output logic [3:0]       grant
);

  always_comb begin
    logic [REQ_W-1:0] idx;
    grant = '0;
    idx   = '0;
    // Walk from farthest to nearest so the requester closest to ptr is written last.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + REQ_W'(k);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hififo_rr_scheduler.sv
// rtl/hififo_rr_scheduler.sv - tags and multiplexes four read-request streams onto one TX request port
module hififo_rr_scheduler
  import hififo_pkg::*;
#(
  parameter logic [10:0] PIO_ADDR = HIFIFO_PIO_ADDR,
  parameter int          SLOTS    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pio_wvalid,
  input  logic [10:0] pio_addr,
  input  logic [63:0] pio_wdata,
  input  logic [3:0]  rr_valid,
  output logic [3:0]  rr_ready,
  input  logic [63:0] rr0_addr,
  input  logic [63:0] rr1_addr,
  input  logic [63:0] rr2_addr,
  input  logic [63:0] rr3_addr,
  output logic        rrm_valid,
  output logic [63:0] rrm_addr,
  output logic [7:0]  rrm_tag,
  input  logic        rrm_ready,
  input  logic        rc_valid,
  input  logic [7:0]  rc_tag,
  input  logic        rc_last,
  output logic [31:0] busy,
  output logic        error
);

  state_t            state;
  logic [3:0]        enable;
  logic [REQ_W-1:0]  ptr;
  logic [3:0]        has_free;
  logic [SLOT_W-1:0] free_slot [4];
  logic [3:0]        eligible;
  logic [3:0]        grant;
  logic [REQ_W-1:0]  gidx;
  logic              take;
  logic [63:0]       req_addr;
  logic              pio_hit;
  logic              rc_hit;
  logic              rc_bad;
  logic [31:0]       alloc_mask;
  logic [31:0]       rel_mask;
  logic [31:0]       flush_mask;
  logic              unused_ok;

  assign unused_ok = ^{pio_wdata[63:12], pio_wdata[7:4]};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      {has_free[i], free_slot[i]} = lowest_free(busy[i*8 +: 8], SLOTS);
    end
  end

  assign eligible = rr_valid & enable & has_free;

  hififo_rr_arb4 u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) gidx = REQ_W'(i);
    end
  end

  assign take     = (state == IDLE) && (|eligible);
  assign rr_ready = (take && !reset) ? grant : 4'b0000;

  always_comb begin
    case (gidx)
      2'd0:    req_addr = rr0_addr;
      2'd1:    req_addr = rr1_addr;
      2'd2:    req_addr = rr2_addr;
      default: req_addr = rr3_addr;
    endcase
  end

  assign pio_hit = pio_wvalid && (pio_addr == PIO_ADDR);
  assign rc_hit  = (rc_tag[7:5] == 3'b000) && (int'(rc_tag[2:0]) < SLOTS) && busy[rc_tag[4:0]];
  assign rc_bad  = rc_valid && !rc_hit;

  always_comb begin
    alloc_mask = '0;
    rel_mask   = '0;
    flush_mask = '0;
    if (take) alloc_mask[{gidx, free_slot[gidx]}] = 1'b1;
    if (rc_valid && rc_last && rc_hit) rel_mask[rc_tag[4:0]] = 1'b1;
    if (pio_hit) begin
      for (int i = 0; i < 4; i++) flush_mask[i*8 +: 8] = {8{pio_wdata[8+i]}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rrm_valid <= 1'b0;
      rrm_addr  <= '0;
      rrm_tag   <= '0;
      busy      <= '0;
      error     <= 1'b0;
      enable    <= 4'b0001;
      ptr       <= '0;
    end else begin
      // Flush masks last so it beats a same-cycle allocation; release and allocate never share a bit.
      busy <= (busy | alloc_mask) & ~rel_mask & ~flush_mask;
      if (rc_bad)  error  <= 1'b1;
      if (pio_hit) enable <= pio_wdata[3:0];
      case (state)
        IDLE: begin
          if (take) begin
            rrm_valid <= 1'b1;
            rrm_addr  <= req_addr;
            rrm_tag   <= {3'b000, gidx, free_slot[gidx]};
            ptr       <= gidx + 2'd1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (rrm_ready) begin
            rrm_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hififo_rr_scheduler.sv
// tb/tb_hififo_rr_scheduler.sv - directed self-checking bench for hififo_rr_scheduler
module tb_hififo_rr_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        pio_wvalid;
  logic [10:0] pio_addr;
  logic [63:0] pio_wdata;
  logic [3:0]  rr_valid;
  logic [3:0]  rr_ready;
  logic [63:0] rr0_addr, rr1_addr, rr2_addr, rr3_addr;
  logic        rrm_valid;
  logic [63:0] rrm_addr;
  logic [7:0]  rrm_tag;
  logic        rrm_ready;
  logic        rc_valid;
  logic [7:0]  rc_tag;
  logic        rc_last;
  logic [31:0] busy;
  logic        error;

  int errors = 0;
  int checks = 0;

  hififo_rr_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .pio_wvalid (pio_wvalid),
    .pio_addr   (pio_addr),
    .pio_wdata  (pio_wdata),
    .rr_valid   (rr_valid),
    .rr_ready   (rr_ready),
    .rr0_addr   (rr0_addr),
    .rr1_addr   (rr1_addr),
    .rr2_addr   (rr2_addr),
    .rr3_addr   (rr3_addr),
    .rrm_valid  (rrm_valid),
    .rrm_addr   (rrm_addr),
    .rrm_tag    (rrm_tag),
    .rrm_ready  (rrm_ready),
    .rc_valid   (rc_valid),
    .rc_tag     (rc_tag),
    .rc_last    (rc_last),
    .busy       (busy),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic pio_write(input logic [63:0] d);
    pio_wvalid = 1'b1;
    pio_addr   = 11'd9;
    pio_wdata  = d;
    cycle();
    pio_wvalid = 1'b0;
  endtask

  logic [7:0] exp_tags [5] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h01};
  logic [3:0] exp_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [63:0] exp_adr [5] = '{64'h1000, 64'h2000, 64'h3000, 64'h4000, 64'h1000};

  initial begin
    reset = 1'b1; pio_wvalid = 1'b0; pio_addr = '0; pio_wdata = '0;
    rr_valid = '0; rrm_ready = 1'b1; rc_valid = 1'b0; rc_tag = '0; rc_last = 1'b0;
    rr0_addr = 64'h1000; rr1_addr = 64'h2000; rr2_addr = 64'h3000; rr3_addr = 64'h4000;

    cycle(); cycle();
    check("rst_rrm_valid", 64'(rrm_valid), 64'd0);
    check("rst_rr_ready", 64'(rr_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_tag", 64'(rrm_tag), 64'd0);
    check("rst_addr", rrm_addr, 64'd0);
    reset = 1'b0;

    // Single requester, back-to-back grants take consecutive slots.
    rr_valid = 4'b0001; #1;
    check("r0_ready", 64'(rr_ready), 64'h1);
    cycle();
    check("r0_valid", 64'(rrm_valid), 64'd1);
    check("r0_tag", 64'(rrm_tag), 64'h00);
    check("r0_addr", rrm_addr, 64'h1000);
    check("r0_busy", 64'(busy), 64'h1);
    check("r0_ready_issue", 64'(rr_ready), 64'h0);
    cycle();
    check("r0_idle_valid", 64'(rrm_valid), 64'd0);
    check("r0_ready2", 64'(rr_ready), 64'h1);
    cycle();
    check("r0_tag2", 64'(rrm_tag), 64'h01);
    check("r0_busy2", 64'(busy), 64'h3);
    rr_valid = 4'b0000;
    cycle();

    rc_valid = 1'b1; rc_last = 1'b0; rc_tag = 8'h00;
    cycle();
    check("rc_nolast_busy", 64'(busy), 64'h3);
    check("rc_nolast_err", 64'(error), 64'd0);
    rc_last = 1'b1;
    cycle();
    rc_tag = 8'h01;
    cycle();
    rc_valid = 1'b0; rc_last = 1'b0;
    check("rc_clear_busy", 64'(busy), 64'h0);

    // Round robin over all four requesters.
    do_reset();
    pio_write(64'hF);
    rr_valid = 4'hF; #1;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rr_gnt%0d", g), 64'(rr_ready), 64'(exp_gnt[g]));
      cycle();
      check($sformatf("rr_tag%0d", g), 64'(rrm_tag), 64'(exp_tags[g]));
      check($sformatf("rr_addr%0d", g), rrm_addr, exp_adr[g]);
      if (g == 4) rr_valid = 4'h0;
      cycle();
    end
    check("rr_busy", 64'(busy), 64'h0101_0103);

    // Requester 0 exhausts its slots; requester 1 still served.
    do_reset();
    pio_write(64'hF);
    rr_valid = 4'b0001; #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_ready%0d", i), 64'(rr_ready), 64'h1);
      cycle();
      check($sformatf("fill_tag%0d", i), 64'(rrm_tag), 64'(i));
      cycle();
    end
    check("fill_busy", 64'(busy), 64'hFF);
    rr_valid = 4'b0011; #1;
    check("full_skip", 64'(rr_ready), 64'h2);
    cycle();
    check("full_r1_tag", 64'(rrm_tag), 64'h08);
    rr_valid = 4'b0001;
    cycle();
    check("full_no_grant", 64'(rr_ready), 64'h0);
    rc_valid = 1'b1; rc_last = 1'b1; rc_tag = 8'h03;
    cycle();
    rc_valid = 1'b0; rc_last = 1'b0; #1;
    check("refill_ready", 64'(rr_ready), 64'h1);
    cycle();
    check("refill_tag", 64'(rrm_tag), 64'h03);
    check("refill_busy", 64'(busy), 64'h1FF);
    rr_valid = 4'b0000;
    cycle();

    // Unexpected completion, then PIO flush of requester 0.
    rc_valid = 1'b1; rc_last = 1'b1; rc_tag = 8'h05;
    cycle();
    check("rc5_busy", 64'(busy), 64'h1DF);
    check("rc5_err", 64'(error), 64'd0);
    cycle();
    rc_valid = 1'b0; rc_last = 1'b0;
    check("bad_err", 64'(error), 64'd1);
    check("bad_busy", 64'(busy), 64'h1DF);
    pio_write(64'h10F);
    check("flush0_busy", 64'(busy), 64'h100);

    // TX backpressure: request held; flush while issuing does not withdraw it.
    rr_valid = 4'b0010; rrm_ready = 1'b0; #1;
    check("bp_ready", 64'(rr_ready), 64'h2);
    cycle();
    check("bp_busy", 64'(busy), 64'h300);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), 64'(rrm_valid), 64'd1);
      check($sformatf("bp_tag%0d", k), 64'(rrm_tag), 64'h09);
      check($sformatf("bp_addr%0d", k), rrm_addr, 64'h2000);
      check($sformatf("bp_noready%0d", k), 64'(rr_ready), 64'h0);
      if (k == 1) begin
        pio_wvalid = 1'b1; pio_addr = 11'd9; pio_wdata = 64'h20F;
      end
      if (k == 2) pio_wvalid = 1'b0;
      cycle();
    end
    check("bp_flush_busy", 64'(busy), 64'h0);
    check("bp_kept_valid", 64'(rrm_valid), 64'd1);
    rrm_ready = 1'b1; rr_valid = 4'b0000;
    cycle();
    check("bp_release", 64'(rrm_valid), 64'd0);

    // Flush beats a same-cycle allocation for the same requester.
    rr_valid = 4'b0010; pio_wvalid = 1'b1; pio_addr = 11'd9; pio_wdata = 64'h20F; #1;
    check("fa_ready", 64'(rr_ready), 64'h2);
    cycle();
    rr_valid = 4'b0000; pio_wvalid = 1'b0; rrm_ready = 1'b0;
    check("fa_tag", 64'(rrm_tag), 64'h08);
    check("fa_busy", 64'(busy), 64'h0);
    cycle();

    // Reset in ISSUE drops the request and restores enable.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mr_valid", 64'(rrm_valid), 64'd0);
    check("mr_busy", 64'(busy), 64'h0);
    check("mr_err", 64'(error), 64'd0);
    rr_valid = 4'b0010; #1;
    check("mr_en1_off", 64'(rr_ready), 64'h0);
    rr_valid = 4'b0011; #1;
    check("mr_en0_on", 64'(rr_ready), 64'h1);
    rrm_ready = 1'b1;
    cycle();
    rr_valid = 4'b0000;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
